// File: rtl/sevenseg_capture.sv
// Seven-segment bus monitor: settles each anode slot, decodes the lit glyph back to hex per digit.
// Define SEVENSEG_CAPTURE_DP_EN to also capture the decimal point per digit.
module sevenseg_capture #(
    parameter int unsigned NDIG   = 6,
    parameter int unsigned STABLE = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [7:0]          an_n,
    input  logic [6:0]          segs_n,
    input  logic                dp_n,
    output logic [4*NDIG-1:0]   digits,
    output logic [NDIG-1:0]     dps,
    output logic [NDIG-1:0]     digit_ok,
    output logic                frame_valid,
    output logic                err
);

`ifdef SEVENSEG_CAPTURE_DP_EN
    localparam int unsigned BW = 16;
`else
    localparam int unsigned BW = 15;
`endif

    logic [BW-1:0] bus;
    logic [BW-1:0] s1_q, s2_q;

`ifdef SEVENSEG_CAPTURE_DP_EN
    assign bus = {an_n, segs_n, dp_n};
`else
    assign bus = {an_n, segs_n};
    logic unused_dp_n;
    assign unused_dp_n = dp_n;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '1;
            s2_q <= '1;
        end else begin
            s1_q <= bus;
            s2_q <= s1_q;
        end
    end

    // s1 vs s2 is the next-cycle view of s2 vs its delayed copy, so the counter
    // clears on the same edge the new value lands in s2.
    logic [7:0] cnt_q, cnt_d;
    logic       capture;

    always_comb begin
        cnt_d   = cnt_q;
        capture = 1'b0;
        if (s1_q != s2_q) begin
            cnt_d = '0;
        end else if (cnt_q < 8'(STABLE)) begin
            cnt_d   = cnt_q + 8'd1;
            capture = (cnt_q == 8'(STABLE - 1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Returns {legal, value}; unknown patterns decode to {0, 0}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b1, 4'h0};
            7'h06:   return {1'b1, 4'h1};
            7'h5B:   return {1'b1, 4'h2};
            7'h4F:   return {1'b1, 4'h3};
            7'h66:   return {1'b1, 4'h4};
            7'h6D:   return {1'b1, 4'h5};
            7'h7D:   return {1'b1, 4'h6};
            7'h07:   return {1'b1, 4'h7};
            7'h7F:   return {1'b1, 4'h8};
            7'h6F:   return {1'b1, 4'h9};
            7'h77:   return {1'b1, 4'hA};
            7'h7C:   return {1'b1, 4'hB};
            7'h39:   return {1'b1, 4'hC};
            7'h5E:   return {1'b1, 4'hD};
            7'h79:   return {1'b1, 4'hE};
            7'h71:   return {1'b1, 4'hF};
            default: return 5'h00;
        endcase
    endfunction

    logic [7:0]      low;
    logic [6:0]      pat;
    logic [4:0]      glyph;
    logic [3:0]      nlow;
    logic            single, multi;
    logic [NDIG-1:0] sel;

    assign low   = ~s2_q[BW-1 -: 8];
    assign pat   = ~s2_q[BW-9 -: 7];
    assign glyph = decode(pat);

    always_comb begin
        nlow = '0;
        for (int i = 0; i < 8; i++) begin
            nlow = nlow + {3'b000, low[i]};
        end
    end

    assign single = (nlow == 4'd1);
    assign multi  = (nlow > 4'd1);
    // A single low anode at index >= NDIG falls outside the slice and selects nothing.
    assign sel    = (capture && single) ? low[NDIG-1:0] : '0;

    logic [4*NDIG-1:0] digits_q, digits_d;
    logic [NDIG-1:0]   ok_q, ok_d;
    logic [NDIG-1:0]   seen_q, seen_d, seen_upd;
    logic              frame_q, frame_d;
    logic              err_q, err_d;

    assign seen_upd = seen_q | sel;

    always_comb begin
        digits_d = digits_q;
        ok_d     = ok_q;
        seen_d   = seen_q;
        frame_d  = 1'b0;
        err_d    = err_q | (capture & multi);
        for (int i = 0; i < NDIG; i++) begin
            if (sel[i]) begin
                digits_d[4*i +: 4] = glyph[3:0];
                ok_d[i]            = glyph[4];
            end
        end
        if (|sel) begin
            // The completing capture closes the frame and is not carried into the next one.
            if (&seen_upd) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d = seen_upd;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q <= '0;
            ok_q     <= '0;
            seen_q   <= '0;
            frame_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            digits_q <= digits_d;
            ok_q     <= ok_d;
            seen_q   <= seen_d;
            frame_q  <= frame_d;
            err_q    <= err_d;
        end
    end

`ifdef SEVENSEG_CAPTURE_DP_EN
    logic [NDIG-1:0] dps_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dps_q <= '0;
        end else begin
            for (int i = 0; i < NDIG; i++) begin
                if (sel[i]) begin
                    dps_q[i] <= ~s2_q[0];
                end
            end
        end
    end

    assign dps = dps_q;
`else
    assign dps = '0;
`endif

    assign digits      = digits_q;
    assign digit_ok    = ok_q;
    assign frame_valid = frame_q;
    assign err         = err_q;

endmodule

// File: tb/tb_sevenseg_capture.sv
// Bench for sevenseg_capture: fixed vector table, hand-timed corner sequences, and randomized
// slots checked against a slot-level reference model.
module tb_sevenseg_capture;

    localparam int unsigned NDIG   = 6;
    localparam int unsigned STABLE = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        an_n = 8'hFF;
    logic [6:0]        segs_n = 7'h7F;
    logic              dp_n = 1'b1;
    logic [4*NDIG-1:0] digits;
    logic [NDIG-1:0]   dps;
    logic [NDIG-1:0]   digit_ok;
    logic              frame_valid;
    logic              err;

    sevenseg_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an_n        (an_n),
        .segs_n      (segs_n),
        .dp_n        (dp_n),
        .digits      (digits),
        .dps         (dps),
        .digit_ok    (digit_ok),
        .frame_valid (frame_valid),
        .err         (err)
    );

    always #5 clk = ~clk;

    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic logic [6:0] enc(input int v);
        return ~glyph[v];
    endfunction

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: one entry per digit plus a count of distinct digits seen this frame.
    logic [3:0] m_dig [8];
    bit         m_ok [8];
    bit         m_dp [8];
    bit         m_seen [8];
    int         m_seen_cnt;
    bit         m_err;
    logic [7:0] last_an;
    logic [6:0] last_segs;

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_dig[i]  = 4'h0;
            m_ok[i]   = 1'b0;
            m_dp[i]   = 1'b0;
            m_seen[i] = 1'b0;
        end
        m_seen_cnt = 0;
        m_err      = 1'b0;
    endtask

    task automatic model_slot(input logic [7:0] an, input logic [6:0] sn, input logic dpn,
                              input int hold, output int pulses);
        int  nlow, idx, val;
        bit  legal;
        pulses = 0;
        nlow   = 0;
        idx    = 0;
        val    = 0;
        legal  = 1'b0;
        if (hold < int'(STABLE) + 1) return;
        for (int i = 0; i < 8; i++) if (!an[i]) begin nlow++; idx = i; end
        if (nlow > 1) begin m_err = 1'b1; return; end
        if (nlow == 0 || idx >= int'(NDIG)) return;
        for (int v = 0; v < 16; v++) if (~sn == glyph[v]) begin legal = 1'b1; val = v; end
        m_dig[idx] = legal ? 4'(val) : 4'h0;
        m_ok[idx]  = legal;
`ifdef SEVENSEG_CAPTURE_DP_EN
        m_dp[idx]  = !dpn;
`else
        m_dp[idx]  = 1'b0;
`endif
        if (!m_seen[idx]) begin
            m_seen[idx] = 1'b1;
            m_seen_cnt++;
            if (m_seen_cnt == int'(NDIG)) begin
                for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
                m_seen_cnt = 0;
                pulses     = 1;
            end
        end
    endtask

    // Called at a negedge; holds the slot for 'hold' rising edges and counts frame pulses.
    task automatic drive(input logic [7:0] an, input logic [6:0] sn, input logic dpn,
                         input int hold, output int pulses);
        pulses    = 0;
        an_n      = an;
        segs_n    = sn;
        dp_n      = dpn;
        last_an   = an;
        last_segs = sn;
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            if (frame_valid) pulses++;
        end
        @(negedge clk);
    endtask

    task automatic slot(input logic [7:0] an, input logic [6:0] sn, input logic dpn, input int hold);
        int got, expp;
        logic [4*NDIG-1:0] e_dig;
        logic [NDIG-1:0]   e_ok, e_dp;
        drive(an, sn, dpn, hold, got);
        model_slot(an, sn, dpn, hold, expp);
        for (int i = 0; i < int'(NDIG); i++) begin
            e_dig[4*i +: 4] = m_dig[i];
            e_ok[i]         = m_ok[i];
            e_dp[i]         = m_dp[i];
        end
        check("digits", 32'(digits), 32'(e_dig));
        check("digit_ok", 32'(digit_ok), 32'(e_ok));
        check("dps", 32'(dps), 32'(e_dp));
        check("err", 32'(err), 32'(m_err));
        check("frame_pulses", 32'(got), 32'(expp));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_digits"}, 32'(digits), 32'h0);
        check({tag, "_ok"}, 32'(digit_ok), 32'h0);
        check({tag, "_dps"}, 32'(dps), 32'h0);
        check({tag, "_frame"}, 32'(frame_valid), 32'h0);
        check({tag, "_err"}, 32'(err), 32'h0);
    endtask

    task automatic do_reset();
        an_n   = 8'hFF;
        segs_n = 7'h7F;
        dp_n   = 1'b1;
        #2 rst_n = 1'b0;
        #1 check_zero("reset");
        repeat (2) @(negedge clk);
        rst_n     = 1'b1;
        last_an   = 8'hFF;
        last_segs = 7'h7F;
        model_reset();
    endtask

    typedef struct {
        logic [7:0]  an;
        logic [6:0]  sn;
        logic        dpn;
        int          hold;
        logic [23:0] dig;
        logic [5:0]  ok;
        logic [5:0]  dp;
        logic        err;
        int          frames;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int got;
        logic [5:0] edp;
        logic [7:0] an;
        logic [6:0] sn;
        logic       dpn;
        int         hold, r, i0, j0;

        vecs[0]  = '{8'hFE, enc(1),  1'b1, 16, 24'h000001, 6'h01, 6'h00, 1'b0, 0};
        vecs[1]  = '{8'hFD, enc(2),  1'b1, 16, 24'h000021, 6'h03, 6'h00, 1'b0, 0};
        vecs[2]  = '{8'hFB, enc(3),  1'b1, 16, 24'h000321, 6'h07, 6'h00, 1'b0, 0};
        vecs[3]  = '{8'hF7, enc(4),  1'b1, 16, 24'h004321, 6'h0F, 6'h00, 1'b0, 0};
        vecs[4]  = '{8'hEF, enc(5),  1'b1, 16, 24'h054321, 6'h1F, 6'h00, 1'b0, 0};
        vecs[5]  = '{8'hDF, enc(6),  1'b1, 16, 24'h654321, 6'h3F, 6'h00, 1'b0, 1};
        vecs[6]  = '{8'hFD, 7'h36,   1'b1, 16, 24'h654301, 6'h3D, 6'h00, 1'b0, 0};
        vecs[7]  = '{8'hF7, 7'h7F,   1'b1, 16, 24'h650301, 6'h35, 6'h00, 1'b0, 0};
        vecs[8]  = '{8'h7F, enc(8),  1'b1, 16, 24'h650301, 6'h35, 6'h00, 1'b0, 0};
        vecs[9]  = '{8'hFB, enc(8),  1'b1, 3,  24'h650301, 6'h35, 6'h00, 1'b0, 0};
        vecs[10] = '{8'hFB, enc(12), 1'b1, 16, 24'h650C01, 6'h35, 6'h00, 1'b0, 0};
        vecs[11] = '{8'hFC, enc(8),  1'b1, 16, 24'h650C01, 6'h35, 6'h00, 1'b1, 0};
        vecs[12] = '{8'hEF, enc(10), 1'b0, 16, 24'h6A0C01, 6'h35, 6'h10, 1'b1, 0};
        vecs[13] = '{8'hFE, enc(0),  1'b1, 16, 24'h6A0C00, 6'h35, 6'h10, 1'b1, 0};
        vecs[14] = '{8'hDF, enc(15), 1'b1, 16, 24'hFA0C00, 6'h35, 6'h10, 1'b1, 1};

        @(negedge clk);
        do_reset();

        for (int v = 0; v < 15; v++) begin
            drive(vecs[v].an, vecs[v].sn, vecs[v].dpn, vecs[v].hold, got);
`ifdef SEVENSEG_CAPTURE_DP_EN
            edp = vecs[v].dp;
`else
            edp = 6'h00;
`endif
            check($sformatf("tbl%0d_digits", v), 32'(digits), 32'(vecs[v].dig));
            check($sformatf("tbl%0d_ok", v), 32'(digit_ok), 32'(vecs[v].ok));
            check($sformatf("tbl%0d_dps", v), 32'(dps), 32'(edp));
            check($sformatf("tbl%0d_err", v), 32'(err), 32'(vecs[v].err));
            check($sformatf("tbl%0d_frames", v), 32'(got), 32'(vecs[v].frames));
        end

        // Capture latency: visible after edge E+1+STABLE, not one edge earlier.
        do_reset();
        an_n   = 8'hFE;
        segs_n = enc(7);
        repeat (STABLE + 1) @(posedge clk);
        #1 check("latency_early", 32'(digits[3:0]), 32'h0);
        @(posedge clk);
        #1 check("latency_edge", 32'(digits[3:0]), 32'h7);
        check("latency_ok", 32'(digit_ok), 32'h01);
        @(negedge clk);

        // Hold boundary: STABLE+1 cycles captures, STABLE cycles does not.
        drive(8'hFD, enc(9), 1'b1, STABLE + 1, got);
        drive(8'hFF, 7'h7F, 1'b1, 8, got);
        check("hold_min_digit", 32'(digits[7:4]), 32'h9);
        drive(8'hFB, enc(5), 1'b1, STABLE, got);
        drive(8'hFF, 7'h7F, 1'b1, 8, got);
        check("hold_short_digit", 32'(digits[11:8]), 32'h0);
        check("hold_ok", 32'(digit_ok), 32'h03);

        // Randomized slots against the model.
        do_reset();
        for (int n = 0; n < 300; n++) begin
            do begin
                r = int'($urandom_range(0, 99));
                if (r < 70) begin
                    an = 8'hFF;
                    an[$urandom_range(0, 7)] = 1'b0;
                end else if (r < 80) begin
                    an = 8'hFF;
                end else if (r < 83) begin
                    i0 = int'($urandom_range(0, 7));
                    j0 = (i0 + 1 + int'($urandom_range(0, 6))) % 8;
                    an = 8'hFF;
                    an[i0] = 1'b0;
                    an[j0] = 1'b0;
                end else begin
                    an = 8'($urandom);
                end
                if ($urandom_range(0, 99) < 75) sn = enc(int'($urandom_range(0, 15)));
                else sn = 7'($urandom);
            end while (an == last_an && sn == last_segs);
            dpn  = 1'($urandom);
            hold = ($urandom_range(0, 99) < 30) ? int'($urandom_range(1, STABLE))
                                                : int'($urandom_range(STABLE + 2, STABLE + 10));
            slot(an, sn, dpn, hold);
        end

        // Reset mid-frame, then a fresh frame needs all NDIG digits again.
        do_reset();
        slot(8'hFE, enc(3), 1'b1, 12);
        slot(8'hFD, enc(4), 1'b0, 12);
        slot(8'hF3, enc(4), 1'b1, 12);
        check("pre_reset_err", 32'(err), 32'h1);
        drive(8'hFB, enc(5), 1'b1, 2, got);
        do_reset();
        for (int d = 0; d < int'(NDIG); d++) begin
            an = 8'hFF;
            an[d] = 1'b0;
            slot(an, enc(d + 9), 1'b1, 10);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sevenseg_capture.md
# sevenseg_capture

Receive-side monitor for the multiplexed, active-low seven-segment display bus produced by the display scan logic. It samples `an_n`/`segs_n`/`dp_n` and waits for each anode slot to settle. It then decodes the lit glyph back to a 4-bit hex value and holds one value per digit. A frame pulse fires once every captured digit has been refreshed. It sits in the self-check/loopback path and on the board-level test harness, opposite the display driver.

## Interface
Parameters:
- `NDIG`, 6, number of digit slots captured (1..8); anode indices `>= NDIG` are ignored
- `STABLE`, 4, consecutive cycles the synchronized bus must be unchanged before a capture (2..255)

Ports:
- `clk`  in  1  system clock
- `rst_n`  in  1  reset; asynchronous, active-low
- `an_n`  in  8  anode enables, active-low, one-hot-low when valid
- `segs_n`  in  7  segments, active-low; bit0=a, bit1=b … bit6=g
- `dp_n`  in  1  decimal point, active-low
- `digits`  out  4*NDIG  decoded hex values; digit i at bits `[4i+3:4i]`
- `dps`  out  NDIG  captured decimal point per digit, active-high
- `digit_ok`  out  NDIG  1 = last capture for digit i was a legal glyph
- `frame_valid`  out  1  one-cycle pulse when all NDIG digits captured since last pulse
- `err`  out  1  sticky: more than one anode seen low at a capture point

## Operation
- Input path: two-flop synchronizer on the {an_n, segs_n, dp_n} bundle (s1, s2), plus delay register s3 = previous s2.
- Stability counter (8-bit, saturating at STABLE): cleared when s2 != s3, incremented when s2 == s3.
- Capture event: the cycle the counter goes STABLE-1 -> STABLE. Exactly one capture per settled slot; no recapture until the bus changes.
- At capture, classify s2.an_n:
  - exactly one bit low, index i < NDIG: capture digit i
  - all high, or index >= NDIG: ignore
  - two or more low: set `err`, no capture
- Glyph decode uses active-high abcdefg pattern P = ~segs_n, with P written as hex of bits {g..a}:
  - 0x3F=0, 0x06=1, 0x5B=2, 0x4F=3, 0x66=4, 0x6D=5, 0x7D=6, 0x07=7
  - 0x7F=8, 0x6F=9, 0x77=A, 0x7C=b, 0x39=C, 0x5E=d, 0x79=E, 0x71=F
  - legal glyph: `digits[i]` = value, `digit_ok[i]`=1
  - any other pattern, including blank 0x00: `digits[i]`=0, `digit_ok[i]`=0
- `dps[i]` = ~s2.dp_n at capture.
- Seen mask (NDIG bits): bit i set on capture of digit i. A capture that completes the mask pulses `frame_valid` and clears the mask, so the completing capture is not counted into the next frame. Recapturing an already-seen digit updates its value and leaves the mask unchanged.
- `err` is cleared only by reset.

## Timing
- Reset values: `digits`=0, `dps`=0, `digit_ok`=0, `frame_valid`=0, `err`=0, seen mask=0, counter=0, s1/s2/s3 = all-ones (idle bus).
- Bus value first sampled into s1 at edge E: s2 at E+1, counter cleared at E+1, capture registered at edge E+1+STABLE; outputs visible after that edge.
- Slots held fewer than STABLE+1 cycles are never captured.
- `frame_valid` is asserted in the same cycle the completing digit's outputs update.
- Reset mid-frame: all state returns to reset values immediately. The first capture after release starts a new frame.

## Configuration
- `SEVENSEG_CAPTURE_DP_EN` defined: decimal-point capture as above.
- Not defined: `dp_n` is not synchronized or stored, `dps` is tied to 0, and `dp_n` changes do not clear the stability counter.

## Test plan
- Reset: assert `rst_n`=0 mid-scan -> all outputs 0 immediately; after release, no `frame_valid` until all NDIG digits have been recaptured.
- Clean scan, NDIG=6, STABLE=4: slots 0..5 show 1,2,3,4,5,6, each held 16 cycles -> `digits`=0x654321, `digit_ok`=6'h3F, exactly one `frame_valid` per full scan. Each digit updates 5 cycles after its slot's first sampling edge.
- Glitch rejection: slot 2 shows 8 for 3 cycles, then C for 16 cycles -> digit 2 becomes C; 8 is never captured.
- Illegal and blank: slot 1 pattern P=0x49, then slot 3 blank -> `digits[1]`=0 with `digit_ok[1]`=0, and `digits[3]`=0 with `digit_ok[3]`=0. Both still count toward the frame.
- Multi-anode: `an_n`=8'hFC held 16 cycles -> `err`=1 and stays 1; no digit changes. `an_n`=8'h7F (index 7, NDIG=6) -> ignored.
- DP (macro defined): slot 4 shows A with `dp_n`=0 -> `dps[4]`=1. With the macro undefined -> `dps` stays 0.
